// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: one fetch port and one load/store port share a single
// fixed-latency memory, one access in flight, alternating on contention.
module mem_port_arbiter #(
  parameter int unsigned LAT = 2
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  output logic        if_stall,

  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        d_stall,

  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,

  output logic        busy,
  output logic        grant_d
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_LAST = CW'(LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e        state_q,     state_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic          we_q,        we_d;
  logic          grant_d_q,   grant_d_d;
  logic          mem_en_q,    mem_en_d;
  logic          mem_we_q,    mem_we_d;
  logic [AW-1:0] mem_addr_q,  mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q,  if_rdata_d;
  logic [DW-1:0] d_rdata_q,   d_rdata_d;
  logic          if_ready_q,  if_ready_d;
  logic          d_ready_q,   d_ready_d;
  logic          busy_q,      busy_d;
  logic          pick_d;

  // Next-state and registered-output logic; grant_d_q doubles as the transaction owner
  // and as the last-grant memory for arbitration.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    grant_d_d   = grant_d_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;
    // Data wins a tie unless data also won the previous grant.
    pick_d      = d_req & (~if_req | ~grant_d_q);

    case (state_q)
      IDLE: begin
        if (if_req | d_req) begin
          grant_d_d = pick_d;
          we_d      = pick_d & d_we;
          mem_en_d  = 1'b1;
          mem_we_d  = pick_d & d_we;
          mem_addr_d = pick_d ? d_addr : if_addr;
          if (pick_d) begin
            mem_wdata_d = d_wdata;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          if (grant_d_q) begin
            d_ready_d = 1'b1;
            if (!we_q) begin
              d_rdata_d = mem_rdata;
            end
          end else begin
            if_ready_d = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      grant_d_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      grant_d_q   <= grant_d_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign d_rdata   = d_rdata_q;
  assign d_ready   = d_ready_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign grant_d   = grant_d_q;

  // Stalls follow the live request so a requester sees the release in its ready cycle.
  assign if_stall = if_req & ~if_ready_q;
  assign d_stall  = d_req & ~d_ready_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named as the codebase does: clk, rst.
REQ-002 Parameter LAT, default 2, SHALL be the memory read latency in cycles (legal range 1..15).
REQ-003 Port: clk  in  1  system clock, rising edge.
REQ-004 Port: rst  in  1  synchronous active-high reset.
REQ-005 Ports: if_req  in  1  fetch request; if_addr  in  32  fetch byte address; if_rdata  out  32  fetched word; if_ready  out  1  fetch complete pulse; if_stall  out  1  fetch stall.
REQ-006 Ports: d_req  in  1  data request; d_we  in  1  write enable; d_addr  in  32  data address; d_wdata  in  32  write data; d_rdata  out  32  load data; d_ready  out  1  data complete pulse; d_stall  out  1  data stall.
REQ-007 Ports: mem_en  out  1  memory strobe; mem_we  out  1  memory write; mem_addr  out  32  memory address; mem_wdata  out  32  memory write data; mem_rdata  in  32  memory read data.
REQ-008 Ports: busy  out  1  transaction in flight; grant_d  out  1  current/last owner (1=data, 0=fetch).

Function
REQ-009 The FSM SHALL have states IDLE, ISSUE, WAIT, DONE; busy = (state != IDLE).
REQ-010 Requests SHALL be sampled in IDLE only; no request is accepted in ISSUE, WAIT or DONE.
REQ-011 Arbitration in IDLE: only one req high -> grant it; both high -> grant data, unless the last grant was data, in which case grant fetch.
REQ-012 On a grant in cycle T, the block SHALL latch owner, address, we (forced 0 for fetch) and wdata, and go to ISSUE.
REQ-013 In ISSUE (cycle T+1), mem_en SHALL be 1 for exactly one cycle with the latched mem_addr/mem_we/mem_wdata; mem_* are registered outputs.
REQ-014 WAIT SHALL count LAT cycles with a 4-bit counter; mem_rdata is valid in cycle T+1+LAT and SHALL be captured into the owner's rdata register at the end of that cycle.
REQ-015 In DONE (cycle T+2+LAT), the owner's ready SHALL be high for exactly one cycle; the next state is IDLE.
REQ-016 Writes SHALL follow the same timing; on a write, d_rdata SHALL be left unchanged.
REQ-017 if_rdata/d_rdata SHALL hold their value until the next completing read for that requester.
REQ-018 if_stall = if_req & ~if_ready and d_stall = d_req & ~d_ready (combinational).
REQ-019 Requesters hold req/addr/we/wdata stable until ready; values are latched at grant, so later changes have no effect on the transaction.
REQ-020 If req drops after grant, the transaction SHALL still complete and ready SHALL still pulse.
REQ-021 When mem_en=0, mem_we SHALL be 0; mem_addr/mem_wdata hold their last value.
REQ-022 grant_d SHALL update at grant and hold until the next grant.
REQ-023 Throughput SHALL be one access per LAT+3 cycles.

Reset
REQ-024 In any state, rst SHALL force IDLE next cycle and abandon any in-flight access with no ready pulse.
REQ-025 Reset values: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, if_rdata=0, d_rdata=0, if_ready=0, d_ready=0, busy=0, grant_d=0, counter=0, last grant=fetch.

Verification (LAT=2)
REQ-026 Reset: hold rst 2 cycles, then release -> all outputs 0, busy=0.
REQ-027 Single fetch: if_req=1, if_addr=0x00000010 at cycle 0 -> cycle 1 mem_en=1, mem_addr=0x10, mem_we=0; memory returns 0x8C080004 in cycle 3 -> cycle 4 if_ready=1, if_rdata=0x8C080004.
REQ-028 Simultaneous requests after reset, both held -> grant order data then fetch; d_ready at cycle 4, if_ready at cycle 9.
REQ-029 Continuous d_req and if_req for 4 transactions -> grants alternate D,F,D,F; no requester starves.
REQ-030 Write: d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF -> cycle 1 mem_en=1, mem_we=1, mem_wdata=0xDEADBEEF; cycle 4 d_ready=1; d_rdata unchanged.
REQ-031 Reset in WAIT (cycle 2) -> cycle 3 busy=0; no ready pulse; a new if_req is granted normally afterwards.
